// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported unified memory between three requesters:
// instruction fetch (IF, read-only), data load/store (DM) and the external
// debug/program loader (DBG). Each requester uses a req/ack handshake. The
// memory has a fixed read latency of MEM_LAT cycles after the mem_en cycle.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   -> round-robin arbitration (2-bit pointer, order if -> dm -> dbg)
//                  undefined -> fixed priority dbg > dm > if (no pointer register)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                IF read request and address
//   if_ack/if_rdata               IF completion pulse and registered read data
//   dm_req/dm_we/dm_addr/dm_wdata DM request (we = 1 write, 0 read)
//   dm_ack/dm_rdata               DM completion pulse and registered read data
//   dbg_*                         DBG channel, same meaning as DM
//   mem_en/mem_we/mem_addr/mem_wdata  memory command, mem_en high one cycle per access
//   mem_rdata                     memory read data, valid MEM_LAT cycles after mem_en
//   gnt                           one-hot owner {dbg, dm, if}, 0 when idle
//   busy                          high whenever a transaction is in flight
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        gnt,
    output logic              busy
);

    localparam logic [3:0] Lat = 4'(MEM_LAT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [2:0]        gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic [2:0]        req;
    logic [2:0]        win;

    assign req = {dbg_req, dm_req, if_req};

`ifdef MEM_ARB_RR_EN
    // Pointer encoding: 0 = if, 1 = dm, 2 = dbg.
    logic [1:0] ptr_q, ptr_d;

    // First requester at or after the pointer, walking if -> dm -> dbg -> if.
    always_comb begin
        win = 3'b000;
        case (ptr_q)
            2'd1: begin
                if (req[1])      win = 3'b010;
                else if (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
            end
            2'd2: begin
                if (req[2])      win = 3'b100;
                else if (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
            end
            default: begin
                if (req[0])      win = 3'b001;
                else if (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
            end
        endcase
    end
`else
    // Fixed priority dbg > dm > if; IF can starve under continuous traffic.
    always_comb begin
        win    = 3'b000;
        win[2] = req[2];
        win[1] = req[1] & ~req[2];
        win[0] = req[0] & ~req[1] & ~req[2];
    end
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
`ifdef MEM_ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    gnt_d   = win;
                    state_d = StIssue;
                    if (win[2]) begin
                        we_d    = dbg_we;
                        addr_d  = dbg_addr;
                        wdata_d = dbg_wdata;
                    end else if (win[1]) begin
                        we_d    = dm_we;
                        addr_d  = dm_addr;
                        wdata_d = dm_wdata;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = if_addr;
                        wdata_d = '0;
                    end
                end
            end
            StIssue: begin
                cnt_d   = Lat;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                // Count of 1 marks the cycle in which mem_rdata is valid.
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                    if (!we_q) begin
                        if (gnt_q[0]) if_rdata_d  = mem_rdata;
                        if (gnt_q[1]) dm_rdata_d  = mem_rdata;
                        if (gnt_q[2]) dbg_rdata_d = mem_rdata;
                    end
                end
            end
            StResp: begin
                gnt_d   = 3'b000;
                state_d = StIdle;
`ifdef MEM_ARB_RR_EN
                case (gnt_q)
                    3'b001:  ptr_d = 2'd1;
                    3'b010:  ptr_d = 2'd2;
                    default: ptr_d = 2'd0;
                endcase
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            gnt_q       <= 3'b000;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= 4'd0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            dbg_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            ptr_q       <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
`ifdef MEM_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign mem_en    = (state_q == StIssue);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign gnt       = gnt_q;
    assign busy      = (state_q != StIdle);
    assign if_ack    = (state_q == StResp) & gnt_q[0];
    assign dm_ack    = (state_q == StResp) & gnt_q[1];
    assign dbg_ack   = (state_q == StResp) & gnt_q[2];
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule
